// File: rtl/dsp_result_fifo.sv
// rtl/dsp_result_fifo.sv - Latency-matched capture FIFO for DSP results
// A valid-bit delay line tracks in-flight operations; each retiring result lands in a FWFT FIFO.
module dsp_result_fifo #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IN_VALID,
    input  logic [47:0]               P,
    input  logic                      CARRYOUTF,
    input  logic                      OUT_READY,
    output logic                      OUT_VALID,
    output logic [47:0]               OUT_DATA,
    output logic                      OUT_CARRY,
    output logic [$clog2(DEPTH):0]    COUNT,
    output logic                      OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [LATENCY-1:0] valid_sr;
    logic [48:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               overflow;
    logic               push;
    logic               pop;
    logic               full;
    logic               write;
    logic [48:0]        head;

    assign push  = valid_sr[LATENCY-1];
    assign full  = (count == FULL_CNT);
    assign pop   = OUT_VALID & OUT_READY;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign write = push & (~full | pop);
    assign head  = mem[rd_ptr];

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = OUT_VALID ? head[47:0] : 48'd0;
    assign OUT_CARRY = OUT_VALID ? head[48]   : 1'b0;
    assign COUNT     = count;
    assign OVERFLOW  = overflow;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= IN_VALID;
            for (int i = 1; i < LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    // Storage needs no reset: OUT_DATA/OUT_CARRY are masked while empty.
    always_ff @(posedge CLK) begin
        if (write) begin
            mem[wr_ptr] <= {CARRYOUTF, P};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({write, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_result_fifo.sv
// tb/tb_dsp_result_fifo.sv - Directed self-checking bench for dsp_result_fifo
module tb_dsp_result_fifo;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic [47:0] P;
    logic        CARRYOUTF;
    logic        OUT_READY;
    logic        OUT_VALID;
    logic [47:0] OUT_DATA;
    logic        OUT_CARRY;
    logic [2:0]  COUNT;
    logic        OVERFLOW;

    int errors = 0;
    int checks = 0;
    int popped;

    dsp_result_fifo #(.LATENCY(4), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .P         (P),
        .CARRYOUTF (CARRYOUTF),
        .OUT_READY (OUT_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_CARRY (OUT_CARRY),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        RST       = 1'b0;
        IN_VALID  = 1'b0;
        P         = '0;
        CARRYOUTF = 1'b0;
        OUT_READY = 1'b0;
        #2;

        // reset held with activity on the inputs
        RST      = 1'b1;
        IN_VALID = 1'b1;
        P        = 48'h1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_out_valid", OUT_VALID, 0);
            check("rst_count", COUNT, 0);
            check("rst_overflow", OVERFLOW, 0);
            check("rst_out_data", OUT_DATA, 0);
        end
        RST      = 1'b0;
        IN_VALID = 1'b0;
        P        = '0;
        repeat (4) tick();
        check("post_rst_count", COUNT, 0);
        check("post_rst_out_valid", OUT_VALID, 0);
        check("post_rst_out_data", OUT_DATA, 0);

        // single-op latency, no bypass before the push edge
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tick();
            check("lat_early_valid", OUT_VALID, 0);
        end
        P = 48'd15;
        tick();
        P = '0;
        check("lat_out_valid", OUT_VALID, 1);
        check("lat_out_data", OUT_DATA, 15);
        check("lat_out_carry", OUT_CARRY, 0);
        check("lat_count", COUNT, 1);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("lat_pop_count", COUNT, 0);
        check("lat_pop_valid", OUT_VALID, 0);

        // fill with five back-to-back ops, fifth is dropped
        for (int c = 0; c < 9; c++) begin
            IN_VALID  = (c < 5);
            P         = (c >= 4) ? 48'(c - 3) : 48'd0;
            CARRYOUTF = (c == 6);
            tick();
            if (c == 7) begin
                check("fill4_count", COUNT, 4);
                check("fill4_overflow", OVERFLOW, 0);
            end
        end
        IN_VALID  = 1'b0;
        P         = '0;
        CARRYOUTF = 1'b0;
        check("fill5_count", COUNT, 4);
        check("fill5_overflow", OVERFLOW, 1);
        OUT_READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("fill_drain_valid", OUT_VALID, 1);
            check("fill_drain_data", OUT_DATA, i);
            check("fill_drain_carry", OUT_CARRY, (i == 3));
            tick();
        end
        OUT_READY = 1'b0;
        check("fill_drain_count", COUNT, 0);
        check("overflow_sticky", OVERFLOW, 1);
        RST = 1'b1;
        #1;
        check("overflow_async_clear", OVERFLOW, 0);
        tick();
        RST = 1'b0;
        tick();

        // full FIFO, push coincides with pop
        for (int c = 0; c < 8; c++) begin
            IN_VALID = (c < 4);
            P        = (c >= 4) ? 48'(c - 3) : 48'd0;
            tick();
        end
        P = '0;
        check("full_count", COUNT, 4);
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        repeat (3) tick();
        P         = 48'd9;
        OUT_READY = 1'b1;
        tick();
        P = '0;
        check("full_pp_count", COUNT, 4);
        check("full_pp_overflow", OVERFLOW, 0);
        check("full_pp_d0", OUT_DATA, 2);
        tick();
        check("full_pp_d1", OUT_DATA, 3);
        tick();
        check("full_pp_d2", OUT_DATA, 4);
        tick();
        check("full_pp_d3", OUT_DATA, 9);
        tick();
        OUT_READY = 1'b0;
        check("full_pp_empty", COUNT, 0);

        // ten results through a depth-4 FIFO with toggling ready
        popped = 0;
        for (int c = 0; c < 30; c++) begin
            IN_VALID  = (c < 20) && (c % 2 == 0);
            P         = (c >= 4 && c <= 22 && c % 2 == 0) ? 48'(100 + (c - 4) / 2) : 48'd0;
            OUT_READY = c[0];
            if (OUT_VALID && OUT_READY) begin
                check("wrap_data", OUT_DATA, 100 + popped);
                popped++;
            end
            tick();
        end
        IN_VALID  = 1'b0;
        P         = '0;
        OUT_READY = 1'b0;
        check("wrap_popped", popped, 10);
        check("wrap_overflow", OVERFLOW, 0);
        check("wrap_count", COUNT, 0);

        // reset two edges after the op is issued
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        P = 48'd77;
        tick();
        P = '0;
        tick();
        check("midrst_count", COUNT, 0);
        check("midrst_valid", OUT_VALID, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
